// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480@60 Hz VGA raster timing, pixel enable and frame pulse.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic       o_p_tick,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_video_on,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_frame_start
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] C_DIV_ONE  = DIV_W'(1);
    localparam logic [9:0]       C_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       C_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       C_H_DISP   = 10'(H_DISP);
    localparam logic [9:0]       C_V_DISP   = 10'(V_DISP);
    localparam logic [9:0]       C_HS_BEG   = 10'(H_DISP + H_FP);
    localparam logic [9:0]       C_HS_END   = 10'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0]       C_VS_BEG   = 10'(V_DISP + V_FP);
    localparam logic [9:0]       C_VS_END   = 10'(V_DISP + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;

    logic             w_p_tick;
    logic [9:0]       w_x_nxt;
    logic [9:0]       w_y_nxt;

    assign w_p_tick = (r_div_cnt == C_DIV_LAST);

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_p_tick) begin
            if (r_x == C_H_LAST) begin
                w_x_nxt = '0;
                w_y_nxt = (r_y == C_V_LAST) ? 10'd0 : r_y + 10'd1;
            end else begin
                w_x_nxt = r_x + 10'd1;
            end
        end
    end

    // Sync/blanking are decoded from the next coordinates so they stay aligned with x/y.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div_cnt  <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b0;
        end else begin
            r_div_cnt  <= w_p_tick ? '0 : r_div_cnt + C_DIV_ONE;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_hsync    <= !((w_x_nxt >= C_HS_BEG) && (w_x_nxt < C_HS_END));
            r_vsync    <= !((w_y_nxt >= C_VS_BEG) && (w_y_nxt < C_VS_END));
            r_video_on <= (w_x_nxt < C_H_DISP) && (w_y_nxt < C_V_DISP);
        end
    end

    assign o_p_tick      = w_p_tick;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_video_on    = r_video_on;
    assign o_frame_start = w_p_tick && (r_x == 10'd0) && (r_y == C_V_DISP);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed checks of a reduced-raster instance plus one default line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int DIV = 4;
    localparam int HD  = 16;
    localparam int HF  = 2;
    localparam int HS  = 4;
    localparam int HB  = 3;
    localparam int VD  = 8;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_f;
    logic       p_tick, vid, hs, vs, fs;
    logic [9:0] x, y;
    logic       f_p_tick, f_vid, f_hs, f_vs, f_fs;
    logic [9:0] f_x, f_y;

    int n_cmp  = 0;
    int n_fail = 0;
    int k_now  = 0;

    always #5 clk = ~clk;

    // Reduced raster: H_TOTAL 25, V_TOTAL 15, frame 1500 clk.
    vga_timing_gen #(
        .CLK_DIV(DIV), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .o_p_tick     (p_tick),
        .o_x          (x),
        .o_y          (y),
        .o_video_on   (vid),
        .o_hsync      (hs),
        .o_vsync      (vs),
        .o_frame_start(fs)
    );

    vga_timing_gen u_full (
        .i_clk        (clk),
        .i_reset      (rst_f),
        .o_p_tick     (f_p_tick),
        .o_x          (f_x),
        .o_y          (f_y),
        .o_video_on   (f_vid),
        .o_hsync      (f_hs),
        .o_vsync      (f_vs),
        .o_frame_start(f_fs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge after rising edge k (counted from reset release).
    task automatic goto(input int k);
        while (k_now < k) begin
            @(negedge clk);
            k_now++;
        end
    endtask

    initial begin
        int fs_cnt, vs_pt, vs_clk, hs_clk, hs_first, vo_first;
        int fs_k[2];
        fs_cnt = 0; vs_pt = 0; vs_clk = 0; hs_clk = 0; hs_first = -1; vo_first = -1;
        fs_k[0] = 0; fs_k[1] = 0;

        rst = 1'b1; rst_f = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_p_tick", p_tick, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_hsync", hs, 1);
        check("rst_vsync", vs, 1);
        check("rst_video_on", vid, 0);
        check("rst_frame_start", fs, 0);

        rst = 1'b0; k_now = 0;
        goto(1);
        check("e1_video_on", vid, 1);
        check("e1_hsync", hs, 1);
        check("e1_vsync", vs, 1);
        check("e1_p_tick", p_tick, 0);
        check("e1_x", x, 0);
        check("e1_y", y, 0);
        goto(2); check("e2_p_tick", p_tick, 0);
        goto(3); check("e3_p_tick", p_tick, 1); check("e3_x", x, 0); check("e3_fs", fs, 0);
        goto(4); check("e4_p_tick", p_tick, 0); check("e4_x", x, 1);
        goto(7); check("e7_p_tick", p_tick, 1);
        goto(8); check("e8_x", x, 2);

        goto(63);  check("x15", x, 15); check("x15_video_on", vid, 1);
        goto(64);  check("x16", x, 16); check("x16_video_on", vid, 0);
        goto(71);  check("x17_hsync", hs, 1);
        goto(72);  check("x18", x, 18); check("x18_hsync", hs, 0);
        goto(87);  check("x21_hsync", hs, 0);
        goto(88);  check("x22_hsync", hs, 1);
        goto(99);  check("x24", x, 24); check("x24_p_tick", p_tick, 1); check("x24_y", y, 0);
        goto(100); check("xwrap_x", x, 0); check("xwrap_y", y, 1);

        // Two full frames: decode relation on every clk, plus frame-level counts.
        for (int i = 0; i < 3000; i++) begin
            goto(k_now + 1);
            check("video_on_map", vid, (x < HD) && (y < VD));
            check("hsync_map", hs, !((x >= HD + HF) && (x < HD + HF + HS)));
            check("vsync_map", vs, !((y >= VD + VF) && (y < VD + VF + VS)));
            if (!vs) begin
                vs_clk++;
                if (p_tick) vs_pt++;
            end
            if (fs) begin
                if (fs_cnt < 2) fs_k[fs_cnt] = k_now;
                fs_cnt++;
                check("fs_x", x, 0);
                check("fs_y", y, VD);
                check("fs_p_tick", p_tick, 1);
            end
            if (k_now == 1499) begin
                check("ywrap_pre_x", x, 24);
                check("ywrap_pre_y", y, 14);
            end
            if (k_now == 1500) begin
                check("ywrap_x", x, 0);
                check("ywrap_y", y, 0);
            end
        end
        check("fs_count", fs_cnt, 2);
        check("fs_first_edge", fs_k[0], 803);
        check("fs_spacing", fs_k[1] - fs_k[0], 1500);
        check("vsync_low_pticks", vs_pt, 100);
        check("vsync_low_clks", vs_clk, 400);

        // Reset while both syncs are active.
        goto(4181);
        check("pre_rst_x", x, 20);
        check("pre_rst_y", y, 11);
        check("pre_rst_hsync", hs, 0);
        check("pre_rst_vsync", vs, 0);
        #2 rst = 1'b1;
        #1;
        check("async_hsync", hs, 1);
        check("async_vsync", vs, 1);
        check("async_x", x, 0);
        check("async_y", y, 0);
        check("async_video_on", vid, 0);
        check("async_p_tick", p_tick, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; k_now = 0;
        goto(1); check("r_e1_video_on", vid, 1); check("r_e1_p_tick", p_tick, 0);
        goto(2); check("r_e2_p_tick", p_tick, 0);
        goto(3); check("r_e3_p_tick", p_tick, 1); check("r_e3_x", x, 0);
        goto(4); check("r_e4_x", x, 1); check("r_e4_p_tick", p_tick, 0);

        // Default 640x480 timing over the first line.
        @(negedge clk);
        rst_f = 1'b0; k_now = 0;
        for (int i = 0; i < 3200; i++) begin
            goto(k_now + 1);
            if (!f_hs) begin
                hs_clk++;
                if (hs_first < 0) hs_first = k_now;
            end
            if (!f_vid && vo_first < 0) vo_first = k_now;
            if (k_now == 3199) begin
                check("full_x799", f_x, 799);
                check("full_x799_p_tick", f_p_tick, 1);
                check("full_x799_y", f_y, 0);
            end
        end
        check("full_wrap_x", f_x, 0);
        check("full_wrap_y", f_y, 1);
        check("full_hsync_clks", hs_clk, 384);
        check("full_hsync_first", hs_first, 2624);
        check("full_video_off_first", vo_first, 2560);
        check("full_vsync", f_vs, 1);
        check("full_frame_start", f_fs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
